// File: rtl/axis_spi_dac_pkg.sv
// Shared definitions for the daisy-chained AD5791 AXI-Stream SPI writer.
package axis_spi_dac_pkg;

  localparam int unsigned AD5791_FRAME_BITS = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_LDAC  = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK generator: idles high, toggles every CLK_DIV cycles while enabled.
module spi_sclk_div
  import axis_spi_dac_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic sclk_o,
  output logic fall_tick_o,
  output logic rise_tick_o
);

  localparam int unsigned CW = (clog2(CLK_DIV) < 1) ? 1 : clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;

  // Ticks coincide with the edge on which sclk toggles.
  always_comb begin
    cnt_d       = cnt_q;
    sclk_d      = sclk_q;
    fall_tick_o = 1'b0;
    rise_tick_o = 1'b0;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b1;
    end else if (cnt_q == LAST) begin
      cnt_d       = '0;
      sclk_d      = ~sclk_q;
      fall_tick_o = sclk_q;
      rise_tick_o = ~sclk_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/axis_spi_dac_chain.sv
// AXI-Stream word -> one SPI frame through N_DEV chained AD5791 DACs, with SYNC gap and LDAC pulse.
module axis_spi_dac_chain
  import axis_spi_dac_pkg::*;
#(
  parameter int unsigned FRAME_BITS = AD5791_FRAME_BITS,
  parameter int unsigned N_DEV      = 2,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned SYNC_IDLE  = 2,
  parameter int unsigned LDAC_EN    = 1,
  parameter int unsigned LDAC_WIDTH = 2
) (
  input  logic                        s_axis_aclk,
  input  logic                        s_axis_aresetn,
  input  logic [FRAME_BITS*N_DEV-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic                        dac_sclk,
  output logic                        dac_sdi,
  output logic                        dac_syncn,
  output logic                        dac_ldacn,
  output logic                        busy
);

  localparam int unsigned TOTAL = FRAME_BITS * N_DEV;
  localparam int unsigned BW    = clog2(TOTAL + 1);
  localparam int unsigned GMAX  = (SYNC_IDLE > LDAC_WIDTH) ? SYNC_IDLE : LDAC_WIDTH;
  localparam int unsigned GW    = clog2(GMAX + 1);

  if (CLK_DIV < 1 || SYNC_IDLE < 1 || N_DEV < 1 || LDAC_WIDTH < 1) begin : g_bad_param
    $error("axis_spi_dac_chain: CLK_DIV, SYNC_IDLE, N_DEV and LDAC_WIDTH must be >= 1");
  end

  state_e            state_q, state_d;
  logic [TOTAL-1:0]  sreg_q, sreg_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic              tready_q, tready_d;
  logic              sdi_q, sdi_d;
  logic              syncn_q, syncn_d;
  logic              ldacn_q, ldacn_d;
  logic              busy_q;
  logic              sclk, fall_tick, rise_tick;

  spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk_i       (s_axis_aclk),
    .rst_ni      (s_axis_aresetn),
    .en_i        (state_q == ST_SHIFT),
    .sclk_o      (sclk),
    .fall_tick_o (fall_tick),
    .rise_tick_o (rise_tick)
  );

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    bit_d    = bit_q;
    gcnt_d   = gcnt_q;
    tready_d = tready_q;
    sdi_d    = sdi_q;
    syncn_d  = syncn_q;
    ldacn_d  = ldacn_q;
    case (state_q)
      ST_IDLE: begin
        tready_d = 1'b1;
        if (s_axis_tvalid && tready_q) begin
          tready_d = 1'b0;
          syncn_d  = 1'b0;
          sdi_d    = s_axis_tdata[TOTAL-1];
          sreg_d   = s_axis_tdata << 1;
          bit_d    = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // bit_q counts falling edges; the rise after the TOTAL-th closes the frame.
        if (fall_tick) begin
          bit_d = bit_q + BW'(1);
        end else if (rise_tick) begin
          if (bit_q == BW'(TOTAL)) begin
            syncn_d = 1'b1;
            sdi_d   = 1'b0;
            gcnt_d  = '0;
            state_d = ST_GAP;
          end else begin
            sdi_d  = sreg_q[TOTAL-1];
            sreg_d = sreg_q << 1;
          end
        end
      end
      ST_GAP: begin
        if (gcnt_q == GW'(SYNC_IDLE - 1)) begin
          gcnt_d = '0;
          if (LDAC_EN != 0) begin
            ldacn_d = 1'b0;
            state_d = ST_LDAC;
          end else begin
            tready_d = 1'b1;
            state_d  = ST_IDLE;
          end
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      ST_LDAC: begin
        if (gcnt_q == GW'(LDAC_WIDTH - 1)) begin
          ldacn_d  = 1'b1;
          tready_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q  <= ST_IDLE;
      sreg_q   <= '0;
      bit_q    <= '0;
      gcnt_q   <= '0;
      tready_q <= 1'b0;
      sdi_q    <= 1'b0;
      syncn_q  <= 1'b1;
      ldacn_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      bit_q    <= bit_d;
      gcnt_q   <= gcnt_d;
      tready_q <= tready_d;
      sdi_q    <= sdi_d;
      syncn_q  <= syncn_d;
      ldacn_q  <= ldacn_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign s_axis_tready = tready_q;
  assign dac_sclk      = sclk;
  assign dac_sdi       = sdi_q;
  assign dac_syncn     = syncn_q;
  assign dac_ldacn     = ldacn_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_axis_spi_dac_chain.sv
// Scoreboard bench: two configurations, random frames, back-to-back, tvalid noise and mid-frame reset.
module tb_axis_spi_dac_chain;

  localparam int A_FB = 24, A_ND = 2, A_CD = 2, A_SI = 2, A_LE = 1, A_LW = 2;
  localparam int B_FB = 24, B_ND = 1, B_CD = 1, B_SI = 2, B_LE = 0, B_LW = 2;

  typedef struct {
    logic [63:0] data;
    int          bits;
    int          low;
    int          tready_low;
    int          ldac_first;
    int          ldac_cnt;
    int          gap;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_a, rst_b;
  logic [A_FB*A_ND-1:0] tdata_a;
  logic [B_FB*B_ND-1:0] tdata_b;
  logic                 tvalid_a, tvalid_b;
  logic tready_a, sclk_a, sdi_a, syncn_a, ldacn_a, busy_a;
  logic tready_b, sclk_b, sdi_b, syncn_b, ldacn_b, busy_b;

  axis_spi_dac_chain #(.FRAME_BITS(A_FB), .N_DEV(A_ND), .CLK_DIV(A_CD), .SYNC_IDLE(A_SI),
                       .LDAC_EN(A_LE), .LDAC_WIDTH(A_LW)) u_a (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_a), .s_axis_tdata(tdata_a),
    .s_axis_tvalid(tvalid_a), .s_axis_tready(tready_a), .dac_sclk(sclk_a),
    .dac_sdi(sdi_a), .dac_syncn(syncn_a), .dac_ldacn(ldacn_a), .busy(busy_a)
  );

  axis_spi_dac_chain #(.FRAME_BITS(B_FB), .N_DEV(B_ND), .CLK_DIV(B_CD), .SYNC_IDLE(B_SI),
                       .LDAC_EN(B_LE), .LDAC_WIDTH(B_LW)) u_b (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_b), .s_axis_tdata(tdata_b),
    .s_axis_tvalid(tvalid_b), .s_axis_tready(tready_b), .dac_sclk(sclk_b),
    .dac_sdi(sdi_b), .dac_syncn(syncn_b), .dac_ldacn(ldacn_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  int pushed_a = 0, hs_a = 0;

  // Monitor state, indexed by DUT (0 = A, 1 = B)
  bit          active [2];
  int          k [2], low [2], falls [2], trl [2], lfirst [2], lcnt [2], high_cnt [2], gap [2];
  bit          lbad [2];
  logic        prev_sclk [2];
  logic [63:0] cap [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: frame timing from the per-frame rules, in plain arithmetic.
  function automatic exp_t model(input int id, input logic [63:0] d, input bit b2b);
    exp_t e;
    int tot, cd, si, le, lw;
    tot = (id == 0) ? A_FB * A_ND : B_FB * B_ND;
    cd  = (id == 0) ? A_CD : B_CD;
    si  = (id == 0) ? A_SI : B_SI;
    le  = (id == 0) ? A_LE : B_LE;
    lw  = (id == 0) ? A_LW : B_LW;
    e.bits       = tot;
    e.data       = d & ((64'd1 << tot) - 64'd1);
    e.low        = 2 * cd * tot;
    e.tready_low = e.low + si + le * lw;
    e.ldac_first = e.low + si + 1;
    e.ldac_cnt   = le * lw;
    // syncn also stays high through the IDLE cycle in which the next handshake happens
    e.gap        = b2b ? (si + le * lw + 1) : 0;
    return e;
  endfunction

  task automatic mon_step(input int id, input logic rstn, input logic syncn, input logic sclk,
                          input logic sdi, input logic ldacn, input logic tready);
    exp_t e;
    string p;
    p = (id == 0) ? "A" : "B";
    if (!rstn) begin
      active[id] = 1'b0;
      high_cnt[id] = 0;
      if (id == 0) qa.delete(); else qb.delete();
      return;
    end
    if (!active[id]) begin
      if (syncn == 1'b0) begin
        active[id] = 1'b1;
        k[id] = 1; low[id] = 1; falls[id] = 0; cap[id] = '0;
        trl[id] = (tready == 1'b0) ? 1 : 0;
        lfirst[id] = 0; lcnt[id] = 0; lbad[id] = 1'b0;
        gap[id] = high_cnt[id];
        prev_sclk[id] = sclk;
      end else begin
        high_cnt[id]++;
      end
      return;
    end
    k[id]++;
    if (syncn == 1'b0) low[id]++;
    if (prev_sclk[id] && !sclk && !syncn) begin
      falls[id]++;
      cap[id] = {cap[id][62:0], sdi};
    end
    prev_sclk[id] = sclk;
    if (ldacn == 1'b0) begin
      if (lcnt[id] == 0) lfirst[id] = k[id];
      lcnt[id]++;
      if (!sclk || !syncn) lbad[id] = 1'b1;
    end
    if (tready == 1'b0) begin
      trl[id]++;
      return;
    end
    active[id] = 1'b0;
    high_cnt[id] = k[id] - low[id];
    if ((id == 0 && qa.size() == 0) || (id == 1 && qb.size() == 0)) begin
      checks++; errors++;
      $display("FAIL %s_unexpected_frame: got a frame, expected none", p);
      return;
    end
    e = (id == 0) ? qa.pop_front() : qb.pop_front();
    chk({p, "_data"},       cap[id],           e.data);
    chk({p, "_falls"},      64'(falls[id]),    64'(e.bits));
    chk({p, "_syncn_low"},  64'(low[id]),      64'(e.low));
    chk({p, "_tready_low"}, 64'(trl[id]),      64'(e.tready_low));
    chk({p, "_ldac_cnt"},   64'(lcnt[id]),     64'(e.ldac_cnt));
    if (e.ldac_cnt > 0) begin
      chk({p, "_ldac_first"}, 64'(lfirst[id]), 64'(e.ldac_first));
      chk({p, "_ldac_quiet"}, 64'(lbad[id]),   64'd0);
    end
    if (e.gap > 0) chk({p, "_gap"}, 64'(gap[id]), 64'(e.gap));
  endtask

  always @(negedge clk) begin
    mon_step(0, rst_a, syncn_a, sclk_a, sdi_a, ldacn_a, tready_a);
    mon_step(1, rst_b, syncn_b, sclk_b, sdi_b, ldacn_b, tready_b);
  end

  always @(posedge clk) if (rst_a && tvalid_a && tready_a) hs_a++;

  function automatic logic rdy(input int id);
    return (id == 0) ? tready_a : tready_b;
  endfunction

  task automatic send(input int id, input logic [63:0] d);
    int n;
    bit b2b;
    b2b = !rdy(id);
    if (id == 0) begin tdata_a = d[47:0]; tvalid_a = 1'b1; end
    else         begin tdata_b = d[23:0]; tvalid_b = 1'b1; end
    n = 0;
    while (!rdy(id) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL send_timeout: tready stayed 0, expected 1");
      tvalid_a = 1'b0; tvalid_b = 1'b0;
      return;
    end
    if (id == 0) begin qa.push_back(model(0, d, b2b)); pushed_a++; end
    else qb.push_back(model(1, d, b2b));
    @(posedge clk); #1;
    if (id == 0) tvalid_a = 1'b0; else tvalid_b = 1'b0;
  endtask

  task automatic wait_idle(input int id);
    int n;
    n = 0;
    while (!rdy(id) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: tready stayed 0, expected 1");
    end
  endtask

  initial begin
    logic [63:0] r;
    int n;
    rst_a = 1'b0; rst_b = 1'b0;
    tvalid_a = 1'b0; tvalid_b = 1'b0;
    tdata_a = '0; tdata_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_tready", {tready_a, tready_b}, 64'd0);
    chk("rst_sclk",   {sclk_a, sclk_b},     64'd3);
    chk("rst_sdi",    {sdi_a, sdi_b},       64'd0);
    chk("rst_syncn",  {syncn_a, syncn_b},   64'd3);
    chk("rst_ldacn",  {ldacn_a, ldacn_b},   64'd3);
    chk("rst_busy",   {busy_a, busy_b},     64'd0);
    rst_a = 1'b1; rst_b = 1'b1;
    @(posedge clk); #1;
    chk("tready_after_reset", {tready_a, tready_b}, 64'd3);

    send(0, 64'h100601_200602);
    #1 chk("busy_in_frame", 64'(busy_a), 64'd1);
    wait_idle(0);
    send(1, 64'h080601);
    wait_idle(1);

    send(0, 64'hAAAAAA_555555);
    send(0, 64'h000001_800000);
    wait_idle(0);

    // tvalid/tdata noise while busy must be ignored
    send(0, 64'h123456_789ABC);
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      if (tready_a) begin tvalid_a = 1'b0; break; end
      r = {$urandom(), $urandom()};
      tdata_a = r[47:0];
      tvalid_a = 1'(($urandom() & 32'd1));
    end
    repeat (5) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      r = {$urandom(), $urandom()};
      send(0, r);
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(0, 250)) @(negedge clk);
    end
    wait_idle(0);
    for (int i = 0; i < 8; i++) begin
      r = {$urandom(), $urandom()};
      send(1, r);
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(0, 70)) @(negedge clk);
    end
    wait_idle(1);

    // Mid-frame asynchronous reset around bit 10
    send(0, 64'hFFFFFF_FFFFFF);
    repeat (41) @(posedge clk);
    #2 rst_a = 1'b0;
    #1;
    chk("midrst_syncn",  64'(syncn_a),  64'd1);
    chk("midrst_sclk",   64'(sclk_a),   64'd1);
    chk("midrst_ldacn",  64'(ldacn_a),  64'd1);
    chk("midrst_tready", 64'(tready_a), 64'd0);
    chk("midrst_busy",   64'(busy_a),   64'd0);
    repeat (2) @(posedge clk);
    #2 rst_a = 1'b1;
    @(posedge clk); #1;
    chk("postrst_tready", 64'(tready_a), 64'd1);
    repeat (30) @(negedge clk);
    chk("postrst_no_replay", 64'(syncn_a), 64'd1);
    send(0, 64'h0);

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d frames outstanding, expected 0", qa.size() + qb.size());
    end
    chk("handshakes_a", 64'(hs_a), 64'(pushed_a));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
